// File: rtl/fact_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fact_pkg
// Description : Shared types and default widths for the factorial math block.
//               The inverse-factorial states use an IF_ prefix so they do not
//               clash with the forward factorial engine's state names.
// Revision    : 1.0 - initial release
// ============================================================================
package fact_pkg;

   localparam int DATA_W_DEF = 16;
   localparam int N_W_DEF    = 8;

   typedef enum logic [1:0] {
      IF_IDLE    = 2'd0,
      IF_SEARCH  = 2'd1,
      IF_DONE_ST = 2'd2
   } inv_fact_state_t;

endpackage
`default_nettype wire

// File: rtl/inv_factorial_if.sv
`default_nettype none
// ============================================================================
// Module      : inv_factorial_if
// Description : Start/done request interface of the inverse-factorial engine.
//               Optional macro INV_FACT_REMAINDER_EN adds the rem_out signal.
// Revision    : 1.0 - initial release
// ============================================================================
interface inv_factorial_if
   import fact_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int N_W    = N_W_DEF
);

   logic              start;
   logic [DATA_W-1:0] fdata_in;
   logic              busy;
   logic              done;
   logic [N_W-1:0]    n_out;
   logic              exact;
`ifdef INV_FACT_REMAINDER_EN
   logic [DATA_W-1:0] rem_out;
`endif

`ifdef INV_FACT_REMAINDER_EN
   modport master (output start, output fdata_in,
                   input busy, input done, input n_out, input exact, input rem_out);
   modport slave  (input start, input fdata_in,
                   output busy, output done, output n_out, output exact, output rem_out);
`else
   modport master (output start, output fdata_in,
                   input busy, input done, input n_out, input exact);
   modport slave  (input start, input fdata_in,
                   output busy, output done, output n_out, output exact);
`endif

endinterface
`default_nettype wire

// File: rtl/fact_mul_cmp.sv
`default_nettype none
// ============================================================================
// Module      : fact_mul_cmp
// Description : Combinational multiply-compare step of the inverse factorial
//               search: prod = acc*(k+1) at full width, compared to target.
//               Optional macro INV_FACT_REMAINDER_EN adds the remainder path.
// Revision    : 1.0 - initial release
// ============================================================================
module fact_mul_cmp
   import fact_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int N_W    = N_W_DEF
) (
   input  wire logic [DATA_W-1:0] acc_i,
   input  wire logic [N_W-1:0]    k_i,
   input  wire logic [DATA_W-1:0] target_i,
   output logic                   prod_le_o,
   output logic [DATA_W-1:0]      acc_next_o,
   output logic                   eq_o,
   output logic                   gt_o
`ifdef INV_FACT_REMAINDER_EN
   ,
   output logic [DATA_W-1:0]      rem_o
`endif
);

   // acc < 2^DATA_W and k+1 <= 2^N_W, so the product always fits in P_W bits.
   localparam int P_W = DATA_W + N_W;

   logic [P_W-1:0] w_acc_ext;
   logic [P_W-1:0] w_k1_ext;
   logic [P_W-1:0] w_prod;

   assign w_acc_ext  = {{N_W{1'b0}}, acc_i};
   assign w_k1_ext   = {{DATA_W{1'b0}}, k_i} + P_W'(1);
   assign w_prod     = w_acc_ext * w_k1_ext;

   assign prod_le_o  = (w_prod <= {{N_W{1'b0}}, target_i});
   // Only consumed when prod_le_o is set, in which case the upper bits are zero.
   assign acc_next_o = w_prod[DATA_W-1:0];
   assign eq_o       = (acc_i == target_i);
   // Only possible for target 0, where even 1! overshoots.
   assign gt_o       = (acc_i > target_i);

`ifdef INV_FACT_REMAINDER_EN
   assign rem_o      = target_i - acc_i;
`endif

endmodule
`default_nettype wire

// File: rtl/inv_factorial.sv
`default_nettype none
// ============================================================================
// Module      : inv_factorial
// Description : Inverse factorial engine. Finds the largest n with n! <= V,
//               one multiply-compare per clock, and flags an exact match.
//               Optional macro INV_FACT_REMAINDER_EN adds rem_out = V - n!.
// Revision    : 1.0 - initial release
// ============================================================================
module inv_factorial
   import fact_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int N_W    = N_W_DEF
) (
   input  wire logic       clk,
   input  wire logic       reset,
   inv_factorial_if.slave  bus
);

   inv_fact_state_t   state_q,  state_d;
   logic [DATA_W-1:0] target_q, target_d;
   logic [DATA_W-1:0] acc_q,    acc_d;
   logic [N_W-1:0]    k_q,      k_d;
   logic [N_W-1:0]    n_out_q,  n_out_d;
   logic              exact_q,  exact_d;
`ifdef INV_FACT_REMAINDER_EN
   logic [DATA_W-1:0] rem_q,    rem_d;
   logic [DATA_W-1:0] w_rem;
`endif

   logic              w_prod_le;
   logic [DATA_W-1:0] w_acc_next;
   logic              w_eq;
   logic              w_gt;
   logic              w_k_max;

   fact_mul_cmp #(
      .DATA_W (DATA_W),
      .N_W    (N_W)
   ) u_mul_cmp (
      .acc_i      (acc_q),
      .k_i        (k_q),
      .target_i   (target_q),
      .prod_le_o  (w_prod_le),
      .acc_next_o (w_acc_next),
      .eq_o       (w_eq),
      .gt_o       (w_gt)
`ifdef INV_FACT_REMAINDER_EN
      ,
      .rem_o      (w_rem)
`endif
   );

   // The counter saturates so n_out can never wrap.
   assign w_k_max = (k_q == {N_W{1'b1}});

   // State and datapath registers; reset aborts any search silently.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IF_IDLE;
         target_q <= '0;
         acc_q    <= '0;
         k_q      <= '0;
         n_out_q  <= '0;
         exact_q  <= 1'b0;
`ifdef INV_FACT_REMAINDER_EN
         rem_q    <= '0;
`endif
      end else begin
         state_q  <= state_d;
         target_q <= target_d;
         acc_q    <= acc_d;
         k_q      <= k_d;
         n_out_q  <= n_out_d;
         exact_q  <= exact_d;
`ifdef INV_FACT_REMAINDER_EN
         rem_q    <= rem_d;
`endif
      end
   end

   // Next-state logic: accept in IDLE, step until product overshoots, report.
   always_comb begin
      state_d  = state_q;
      target_d = target_q;
      acc_d    = acc_q;
      k_d      = k_q;
      n_out_d  = n_out_q;
      exact_d  = exact_q;
`ifdef INV_FACT_REMAINDER_EN
      rem_d    = rem_q;
`endif
      case (state_q)
         IF_IDLE: begin
            if (bus.start) begin
               target_d = bus.fdata_in;
               acc_d    = DATA_W'(1);
               k_d      = N_W'(1);
               state_d  = IF_SEARCH;
            end
         end
         IF_SEARCH: begin
            if (w_prod_le && !w_k_max) begin
               acc_d = w_acc_next;
               k_d   = k_q + N_W'(1);
            end else begin
               state_d = IF_DONE_ST;
               n_out_d = w_gt ? '0 : k_q;
               exact_d = w_eq;
`ifdef INV_FACT_REMAINDER_EN
               rem_d   = w_gt ? '0 : w_rem;
`endif
            end
         end
         IF_DONE_ST: begin
            state_d = IF_IDLE;
         end
         default: begin
            state_d = IF_IDLE;
         end
      endcase
   end

   assign bus.busy  = (state_q != IF_IDLE);
   assign bus.done  = (state_q == IF_DONE_ST);
   assign bus.n_out = n_out_q;
   assign bus.exact = exact_q;
`ifdef INV_FACT_REMAINDER_EN
   assign bus.rem_out = rem_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_inv_factorial.sv
`default_nettype none
// ============================================================================
// Module      : tb_inv_factorial
// Description : Self-checking bench for inv_factorial. Expected results come
//               from a plain-arithmetic factorial table model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_inv_factorial;
   import fact_pkg::*;

   localparam int DATA_W = 16;
   localparam int N_W    = 8;

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;

   inv_factorial_if #(.DATA_W(DATA_W), .N_W(N_W)) bus ();

   inv_factorial #(.DATA_W(DATA_W), .N_W(N_W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
      end
   endtask

   // Largest n with n! <= v, by walking the factorial sequence.
   task automatic ref_model(input logic [15:0] v, output int n, output bit ex, output int rem);
      longint f  = 1;
      longint fn = 1;
      n = 0;
      for (int m = 1; m <= 20; m++) begin
         f = f * m;
         if (f <= longint'(v)) begin
            n  = m;
            fn = f;
         end else begin
            break;
         end
      end
      ex  = (fn == longint'(v));
      rem = (n == 0) ? 0 : int'(longint'(v) - fn);
   endtask

   // One full request; poke>=0 pulses a second start that many cycles in.
   task automatic run_op(input logic [15:0] v, input int poke, input string tag);
      int  n_exp;
      bit  ex_exp;
      int  rem_exp;
      int  lat;
      int  busy_cnt;
      ref_model(v, n_exp, ex_exp, rem_exp);
      bus.start    = 1'b1;
      bus.fdata_in = v;
      tick();
      bus.start    = 1'b0;
      bus.fdata_in = 16'($urandom);
      lat      = 0;
      busy_cnt = bus.busy ? 1 : 0;
      while (!bus.done && lat < 300) begin
         tick();
         lat++;
         if (bus.busy) busy_cnt++;
         if (poke >= 0 && lat == poke) begin
            bus.start    = 1'b1;
            bus.fdata_in = 16'd24;
         end else begin
            bus.start    = 1'b0;
         end
      end
      bus.start = 1'b0;
      check({tag, " done_seen"}, 32'(bus.done), 32'd1);
      check({tag, " latency"}, 32'(lat), 32'((n_exp == 0) ? 1 : n_exp));
      check({tag, " n_out"}, 32'(bus.n_out), 32'(n_exp));
      check({tag, " exact"}, 32'(bus.exact), 32'(ex_exp));
      check({tag, " busy_cycles"}, 32'(busy_cnt), 32'(lat + 1));
`ifdef INV_FACT_REMAINDER_EN
      check({tag, " rem_out"}, 32'(bus.rem_out), 32'(rem_exp));
`endif
      tick();
      check({tag, " done_pulse"}, 32'(bus.done), 32'd0);
      check({tag, " idle_after"}, 32'(bus.busy), 32'd0);
      check({tag, " n_hold"}, 32'(bus.n_out), 32'(n_exp));
   endtask

   initial begin
      int          n_tmp;
      bit          ex_tmp;
      int          rem_tmp;
      logic [15:0] facts [9];
      logic [15:0] v;
      bit          saw_done;

      facts[0] = 16'd1;     facts[1] = 16'd1;    facts[2] = 16'd2;
      facts[3] = 16'd6;     facts[4] = 16'd24;   facts[5] = 16'd120;
      facts[6] = 16'd720;   facts[7] = 16'd5040; facts[8] = 16'd40320;

      bus.start    = 1'b0;
      bus.fdata_in = '0;
      reset        = 1'b1;
      tick();
      tick();
      check("rst busy",  32'(bus.busy),  32'd0);
      check("rst done",  32'(bus.done),  32'd0);
      check("rst n_out", 32'(bus.n_out), 32'd0);
      check("rst exact", 32'(bus.exact), 32'd0);
      reset = 1'b0;
      tick();

      // Directed points from the test plan.
      run_op(16'd120,   -1, "v120");
      run_op(16'd100,   -1, "v100");
      run_op(16'd0,     -1, "v0");
      run_op(16'd1,     -1, "v1");
      run_op(16'd40320, -1, "v40320");
      run_op(16'd65535, -1, "v65535");

      // Second start two cycles into a search must be ignored.
      run_op(16'd720, 2, "busy_ignore");
      repeat (3) tick();
      check("hold n_out", 32'(bus.n_out), 32'd6);
      check("hold exact", 32'(bus.exact), 32'd1);

      // Reset three cycles into a search aborts with no done.
      bus.start    = 1'b1;
      bus.fdata_in = 16'd720;
      tick();
      bus.start    = 1'b0;
      repeat (3) tick();
      reset = 1'b1;
      #1;
      check("abort busy",  32'(bus.busy),  32'd0);
      check("abort n_out", 32'(bus.n_out), 32'd0);
      check("abort exact", 32'(bus.exact), 32'd0);
      tick();
      reset    = 1'b0;
      saw_done = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (bus.done) saw_done = 1'b1;
      end
      check("abort no_done", 32'(saw_done), 32'd0);
      run_op(16'd6, -1, "after_reset");

      // Randomized values: exact factorials, neighbours, and arbitrary words.
      for (int i = 0; i < 24; i++) begin
         case ($urandom_range(0, 2))
            0: v = facts[$urandom_range(0, 8)];
            1: v = facts[$urandom_range(1, 8)] - 16'd1;
            default: v = 16'($urandom);
         endcase
         ref_model(v, n_tmp, ex_tmp, rem_tmp);
         run_op(v, -1, $sformatf("rand%0d_v%0d", i, v));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Watchdog so the run always ends.
   initial begin
      #2000000;
      errors++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire
